// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write-stream receiver:
// bus widths, DDRAM geometry, command codes, FSM states and address helpers.
package lcd_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AC_W   = 7;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DROP_W = 8;

  localparam logic [AC_W-1:0] LINE1_BASE = 7'h00;
  localparam logic [AC_W-1:0] LINE2_BASE = 7'h40;
  localparam int unsigned     LINE_LEN   = 16;
  localparam int unsigned     CELLS      = 32;
  localparam logic [AC_W-1:0] LINE1_LAST = LINE1_BASE + AC_W'(LINE_LEN - 1);
  localparam logic [AC_W-1:0] LINE2_LAST = LINE2_BASE + AC_W'(LINE_LEN - 1);

  localparam logic [DATA_W-1:0] BLANK = 8'h20;

  // Command codes; each command is identified by its highest set bit.
  localparam logic [DATA_W-1:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [DATA_W-1:0] CMD_SET_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] CMD_FUNC_SET  = 8'h20;
  localparam logic [DATA_W-1:0] CMD_SHIFT     = 8'h10;
  localparam logic [DATA_W-1:0] CMD_DISPLAY   = 8'h08;
  localparam logic [DATA_W-1:0] CMD_ENTRY     = 8'h04;
  localparam logic [DATA_W-1:0] CMD_HOME      = 8'h02;
  localparam logic [DATA_W-1:0] CMD_CLEAR     = 8'h01;

  localparam int unsigned DISP_D_BIT   = 2;
  localparam int unsigned ENTRY_ID_BIT = 1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  typedef enum logic [2:0] {
    CMDK_NONE,
    CMDK_SET_DDRAM,
    CMDK_DISPLAY,
    CMDK_ENTRY,
    CMDK_HOME,
    CMDK_CLEAR
  } cmd_e;

  // Priority decode of a command byte by its highest set bit.
  function automatic cmd_e decode_cmd(input logic [DATA_W-1:0] d);
    cmd_e k;
    k = CMDK_NONE;
    if (|(d & CMD_SET_DDRAM))                               k = CMDK_SET_DDRAM;
    else if (|(d & (CMD_SET_CGRAM | CMD_FUNC_SET | CMD_SHIFT))) k = CMDK_NONE;
    else if (|(d & CMD_DISPLAY))                            k = CMDK_DISPLAY;
    else if (|(d & CMD_ENTRY))                              k = CMDK_ENTRY;
    else if (|(d & CMD_HOME))                               k = CMDK_HOME;
    else if (|(d & CMD_CLEAR))                              k = CMDK_CLEAR;
    return k;
  endfunction

  // DDRAM address to cell index: {AC[6], AC[3:0]}.
  function automatic logic [IDX_W-1:0] ac_to_idx(input logic [AC_W-1:0] ac);
    return IDX_W'(((ac >> 2) & 7'h10) | (ac & 7'h0F));
  endfunction

  // Only 0x00-0x0F and 0x40-0x4F map to visible cells.
  function automatic logic ddram_addr_ok(input logic [AC_W-1:0] a);
    return (a & 7'h30) == 7'h00;
  endfunction

endpackage

// File: rtl/lcd_char_receiver_if.sv
// LCD write bus plus the receiver's read port and status outputs.
interface lcd_char_receiver_if;
  import lcd_pkg::*;

  logic              RW_INPUT;
  logic              RS_INPUT;
  logic [DATA_W-1:0] DATA_INPUT;
  logic [IDX_W-1:0]  RD_ADDR;
  logic [DATA_W-1:0] RD_CHAR;
  logic [AC_W-1:0]   AC;
  logic              BUSY;
  logic              DISPLAY_ON;
  logic              FRAME_PULSE;
  logic              ILLEGAL;
  logic [DROP_W-1:0] DROP_CNT;

  modport master (
    output RW_INPUT, RS_INPUT, DATA_INPUT, RD_ADDR,
    input  RD_CHAR, AC, BUSY, DISPLAY_ON, FRAME_PULSE, ILLEGAL, DROP_CNT
  );

  modport slave (
    input  RW_INPUT, RS_INPUT, DATA_INPUT, RD_ADDR,
    output RD_CHAR, AC, BUSY, DISPLAY_ON, FRAME_PULSE, ILLEGAL, DROP_CNT
  );

endinterface

// File: rtl/lcd_ac_step.sv
// Next DDRAM address after a data write, for either entry direction,
// wrapping between the two visible lines.
module lcd_ac_step
  import lcd_pkg::*;
(
  input  logic [AC_W-1:0] i_ac,
  input  logic            i_inc,
  output logic [AC_W-1:0] o_ac_nxt_c
);

  always_comb begin
    o_ac_nxt_c = i_ac;
    if (i_inc) begin
      if (i_ac == LINE1_LAST)      o_ac_nxt_c = LINE2_BASE;
      else if (i_ac == LINE2_LAST) o_ac_nxt_c = LINE1_BASE;
      else                         o_ac_nxt_c = i_ac + AC_W'(1);
    end else begin
      if (i_ac == LINE1_BASE)      o_ac_nxt_c = LINE2_LAST;
      else if (i_ac == LINE2_BASE) o_ac_nxt_c = LINE1_LAST;
      else                         o_ac_nxt_c = i_ac - AC_W'(1);
    end
  end

endmodule

// File: rtl/lcd_char_receiver.sv
// Decodes the character-LCD write stream into a 32-cell DDRAM image with
// address counter, clear sweep, status flags and a registered read port.
module lcd_char_receiver
  import lcd_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  lcd_char_receiver_if.slave  lcd
);

  localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_busy_cnt;
  logic [DATA_W-1:0] r_ddram [CELLS];
  logic [AC_W-1:0]   r_ac;
  logic              r_id;
  logic [DATA_W-1:0] r_rd_char;
  logic              r_busy;
  logic              r_display_on;
  logic              r_frame_pulse;
  logic              r_illegal;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_wr_evt;
  logic              w_idle;
  logic              w_data_wr;
  logic              w_cmd_wr;
  logic              w_start_clear;
  logic              w_sweep_done;
  cmd_e              w_cmd;
  logic [AC_W-1:0]   w_ac_step;

  assign w_wr_evt      = !lcd.RW_INPUT;
  assign w_idle        = (r_state == ST_IDLE);
  assign w_data_wr     = w_wr_evt && lcd.RS_INPUT && w_idle;
  assign w_cmd_wr      = w_wr_evt && !lcd.RS_INPUT && w_idle;
  assign w_cmd         = decode_cmd(lcd.DATA_INPUT);
  assign w_start_clear = w_cmd_wr && (w_cmd == CMDK_CLEAR);
  assign w_sweep_done  = (r_state == ST_CLEAR) &&
                         (r_busy_cnt == CNT_W'(CLEAR_CYCLES - 1));

  lcd_ac_step u_ac_step (
    .i_ac       (r_ac),
    .i_inc      (r_id),
    .o_ac_nxt_c (w_ac_step)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_clear) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_sweep_done)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // DDRAM image, address counter, sweep counter and status flags.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < int'(CELLS); i++) r_ddram[i] <= BLANK;
      r_ac          <= LINE1_BASE;
      r_id          <= 1'b1;
      r_rd_char     <= BLANK;
      r_busy        <= 1'b0;
      r_busy_cnt    <= '0;
      r_display_on  <= 1'b0;
      r_frame_pulse <= 1'b0;
      r_illegal     <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      r_frame_pulse <= 1'b0;
      r_rd_char     <= r_ddram[lcd.RD_ADDR];

      if (r_state == ST_CLEAR) begin
        // Sweep blanks one cell per busy cycle; bus writes are discarded.
        if (32'(r_busy_cnt) < CELLS) r_ddram[r_busy_cnt[IDX_W-1:0]] <= BLANK;
        r_busy_cnt <= r_busy_cnt + CNT_W'(1);
        if (w_sweep_done) r_busy <= 1'b0;
        if (w_wr_evt && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end

      if (w_data_wr) begin
        r_ddram[ac_to_idx(r_ac)] <= lcd.DATA_INPUT;
        r_ac                     <= w_ac_step;
        r_frame_pulse            <= (r_ac == LINE2_LAST);
      end

      if (w_cmd_wr) begin
        case (w_cmd)
          CMDK_SET_DDRAM: begin
            if (ddram_addr_ok(lcd.DATA_INPUT[AC_W-1:0])) r_ac <= lcd.DATA_INPUT[AC_W-1:0];
            else                                          r_illegal <= 1'b1;
          end
          CMDK_DISPLAY: r_display_on <= lcd.DATA_INPUT[DISP_D_BIT];
          CMDK_ENTRY:   r_id         <= lcd.DATA_INPUT[ENTRY_ID_BIT];
          CMDK_HOME:    r_ac         <= LINE1_BASE;
          CMDK_CLEAR: begin
            r_ac       <= LINE1_BASE;
            r_id       <= 1'b1;
            r_busy     <= 1'b1;
            r_busy_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign lcd.RD_CHAR     = r_rd_char;
  assign lcd.AC          = r_ac;
  assign lcd.BUSY        = r_busy;
  assign lcd.DISPLAY_ON  = r_display_on;
  assign lcd.FRAME_PULSE = r_frame_pulse;
  assign lcd.ILLEGAL     = r_illegal;
  assign lcd.DROP_CNT    = r_drop_cnt;

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Directed bench for lcd_char_receiver: frame stream, wraps, clear sweep,
// illegal address, display control and reset during a sweep.
module tb_lcd_char_receiver;

  logic CLK;
  logic RESET;
  int   n_err;
  int   n_chk;
  int   pulse_cnt;

  lcd_char_receiver_if lcd ();

  lcd_char_receiver #(.CLEAR_CYCLES(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .lcd   (lcd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (lcd.FRAME_PULSE === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus write at the falling edge; it is taken on the next rising edge.
  task automatic wr(input logic rs, input logic [7:0] d);
    @(negedge CLK);
    lcd.RW_INPUT   = 1'b0;
    lcd.RS_INPUT   = rs;
    lcd.DATA_INPUT = d;
  endtask

  task automatic idle();
    @(negedge CLK);
    lcd.RW_INPUT = 1'b1;
  endtask

  task automatic rd(input int idx, input logic [7:0] exp, input string tag);
    @(negedge CLK);
    lcd.RW_INPUT = 1'b1;
    lcd.RD_ADDR  = 5'(idx);
    @(negedge CLK);
    chk(tag, 32'(lcd.RD_CHAR), 32'(exp));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ac"},    32'(lcd.AC),          32'h00);
    chk({tag, "_busy"},  32'(lcd.BUSY),        32'h0);
    chk({tag, "_disp"},  32'(lcd.DISPLAY_ON),  32'h0);
    chk({tag, "_frame"}, 32'(lcd.FRAME_PULSE), 32'h0);
    chk({tag, "_ill"},   32'(lcd.ILLEGAL),     32'h0);
    chk({tag, "_drop"},  32'(lcd.DROP_CNT),    32'h0);
    chk({tag, "_rd"},    32'(lcd.RD_CHAR),     32'h20);
  endtask

  initial begin
    string line1;
    string line2;
    int    p0;
    line1     = "  MINHO'S CLOCK ";
    line2     = "    AM 00:00:00 ";
    n_err     = 0;
    n_chk     = 0;
    pulse_cnt = 0;

    RESET          = 1'b0;
    lcd.RW_INPUT   = 1'b1;
    lcd.RS_INPUT   = 1'b0;
    lcd.DATA_INPUT = 8'h00;
    lcd.RD_ADDR    = 5'd0;
    repeat (2) @(negedge CLK);
    chk_reset_state("rst");
    RESET = 1'b1;
    for (int i = 0; i < 32; i++) rd(i, 8'h20, "rst_cell");

    // Main-mode frame stream
    p0 = pulse_cnt;
    wr(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) wr(1'b1, line1[i]);
    wr(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) wr(1'b1, line2[i]);
    idle();
    chk("frame_pulse", 32'(lcd.FRAME_PULSE), 32'h1);
    chk("frame_ac_wrap", 32'(lcd.AC), 32'h00);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h20);
    idle();
    chk("frame_ac_end", 32'(lcd.AC), 32'h02);
    chk("frame_pulse_cnt", 32'(pulse_cnt - p0), 32'h1);
    for (int i = 0; i < 16; i++) rd(i, line1[i], "line1");
    for (int i = 0; i < 16; i++) rd(16 + i, line2[i], "line2");

    // Line wraps in both directions
    wr(1'b0, 8'h8F); wr(1'b1, "A"); idle();
    chk("inc_wrap_0f", 32'(lcd.AC), 32'h40);
    wr(1'b0, 8'hCF); wr(1'b1, "B"); idle();
    chk("inc_wrap_4f", 32'(lcd.AC), 32'h00);
    chk("inc_pulse", 32'(lcd.FRAME_PULSE), 32'h1);
    wr(1'b0, 8'h04); wr(1'b1, "C"); idle();
    chk("dec_wrap_00", 32'(lcd.AC), 32'h4F);
    wr(1'b0, 8'hC0); wr(1'b1, "D"); idle();
    chk("dec_wrap_40", 32'(lcd.AC), 32'h0F);
    wr(1'b0, 8'hCF); wr(1'b1, "E"); idle();
    chk("dec_pulse", 32'(lcd.FRAME_PULSE), 32'h1);
    chk("dec_ac", 32'(lcd.AC), 32'h4E);
    rd(15, "A", "cell_0f");
    rd(31, "E", "cell_4f");
    rd(0,  "C", "cell_00");
    rd(16, "D", "cell_40");

    // Read and write of the same cell on one edge returns the old value
    wr(1'b0, 8'h06);
    wr(1'b0, 8'h85);
    lcd.RD_ADDR = 5'd5;
    wr(1'b1, "M");
    idle();
    chk("rd_old", 32'(lcd.RD_CHAR), 32'(line1[5]));
    idle();
    chk("rd_new", 32'(lcd.RD_CHAR), 32'(8'h4D));

    // Clear sweep with a write on every busy cycle
    wr(1'b0, 8'h04);
    wr(1'b0, 8'h01);
    for (int k = 0; k < 32; k++) begin
      wr(1'b1, "X");
      chk("clr_busy", 32'(lcd.BUSY), 32'h1);
    end
    wr(1'b1, "Z");
    chk("clr_busy_end", 32'(lcd.BUSY), 32'h0);
    chk("clr_drop", 32'(lcd.DROP_CNT), 32'd32);
    idle();
    chk("clr_ac_inc", 32'(lcd.AC), 32'h01);
    rd(0, "Z", "clr_cell0");
    for (int i = 1; i < 32; i++) rd(i, 8'h20, "clr_cell");

    // Illegal address and display control
    wr(1'b0, 8'h95); idle();
    chk("ill_flag", 32'(lcd.ILLEGAL), 32'h1);
    chk("ill_ac", 32'(lcd.AC), 32'h01);
    wr(1'b0, 8'h0C); idle();
    chk("disp_on", 32'(lcd.DISPLAY_ON), 32'h1);
    chk("ill_sticky", 32'(lcd.ILLEGAL), 32'h1);

    // Reset on cycle 10 of a sweep
    wr(1'b0, 8'hC4); wr(1'b1, "Q");
    wr(1'b0, 8'h01);
    repeat (9) idle();
    chk("mid_busy", 32'(lcd.BUSY), 32'h1);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    chk_reset_state("mid_rst");
    rd(20, 8'h20, "mid_rst_cell");
    wr(1'b1, "R"); idle();
    chk("mid_rst_id_inc", 32'(lcd.AC), 32'h01);
    chk("mid_rst_not_busy", 32'(lcd.BUSY), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
